// File: rtl/xgmii_frame_gen_32b.sv
// XGMII frame source, 32-bit TX interface.
// Emits back-to-back Ethernet frames: START, SFD, an incrementing payload
// (byte k = k mod 256), a CRC-32 FCS, a terminate, then a programmable
// number of idle words.
// xgmii_tx packs the word as {ctrl[3:0], data[31:0]}; lane n is
// data[8n+7:8n] with control bit ctrl[n].
module xgmii_frame_gen_32b #(
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [13:0] frame_len,
  input  logic [7:0]  ipg_words,
  output logic [35:0] xgmii_tx,
  output logic        busy,
  output logic [31:0] frames_sent
);

  localparam logic [35:0] IDLE_W  = {4'hF, 32'h07070707};
  localparam logic [35:0] START_W = {4'h1, 32'h555555FB};
  localparam logic [35:0] SFD_W   = {4'h0, 32'hD5555555};
  localparam logic [13:0] MIN_L   = 14'(MIN_LEN);

  typedef enum logic [2:0] {S_IDLE, S_START, S_SFD, S_DATA, S_IPG} state_t;

  state_t       state_q, state_d;
  logic [13:0]  len_q, len_d;
  logic [7:0]   ipg_q, ipg_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [14:0]  byte_q, byte_d;
  logic [31:0]  crc_q, crc_d;
  logic [35:0]  tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         term_q, term_d;
  logic         init_q, init_d;
  logic [31:0]  frames_q, frames_d;

  logic [31:0]  crc_new;
  logic [31:0]  gen_data;
  logic [3:0]   gen_ctrl;
  logic         gen_term;
  logic         go;

  // Reflected CRC-32 (poly 0x04C11DB7 reversed) over the enabled lanes,
  // lane 0 first. Unrolls to a 4-byte XOR tree.
  function automatic logic [31:0] crc_bytes(input logic [31:0] crc_in,
                                            input logic [31:0] data,
                                            input logic [3:0]  en);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        c = c ^ {24'd0, data[8*i +: 8]};
        for (int b = 0; b < 8; b++) begin
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  // Build the data word starting at frame byte byte_q. Payload bytes of
  // this word are folded into the CRC first, so FCS bytes sharing the word
  // use the already-final value.
  always_comb begin : gen_word
    logic [14:0] k;
    logic [14:0] len_x;
    logic [14:0] pay_end;
    logic [31:0] pay_data;
    logic [3:0]  pay_mask;
    logic [31:0] fcs;
    logic [1:0]  fidx;
    k        = '0;
    len_x    = {1'b0, len_q};
    pay_end  = len_x - 15'd4;
    pay_data = '0;
    pay_mask = '0;
    fidx     = '0;
    for (int i = 0; i < 4; i++) begin
      k = byte_q + 15'(i);
      pay_data[8*i +: 8] = k[7:0];
      pay_mask[i] = (k < pay_end);
    end
    crc_new  = crc_bytes(crc_q, pay_data, pay_mask);
    fcs      = ~crc_new;
    gen_data = '0;
    gen_ctrl = '0;
    gen_term = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k = byte_q + 15'(i);
      if (k < pay_end) begin
        gen_data[8*i +: 8] = k[7:0];
      end else if (k < len_x) begin
        fidx = k[1:0] - pay_end[1:0];
        gen_data[8*i +: 8] = fcs[{fidx, 3'b000} +: 8];
      end else if (k == len_x) begin
        gen_data[8*i +: 8] = 8'hFD;
        gen_ctrl[i] = 1'b1;
        gen_term = 1'b1;
      end else begin
        gen_data[8*i +: 8] = 8'h07;
        gen_ctrl[i] = 1'b1;
      end
    end
  end

  // Next-state and next-output logic; state_q always names the word
  // currently on xgmii_tx. Length and gap are both latched when START is
  // decided so a frame and its trailing gap use one consistent setting.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    ipg_d    = ipg_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    crc_d    = crc_q;
    tx_d     = IDLE_W;
    busy_d   = 1'b0;
    term_d   = 1'b0;
    init_d   = 1'b0;
    frames_d = term_q ? (frames_q + 32'd1) : frames_q;
    go       = 1'b0;
    case (state_q)
      S_IDLE: begin
        go = enable && !init_q;
      end
      S_START: begin
        state_d = S_SFD;
        tx_d    = SFD_W;
        busy_d  = 1'b1;
        byte_d  = '0;
        crc_d   = '1;
      end
      S_SFD, S_DATA: begin
        if (state_q == S_DATA && term_q) begin
          state_d = S_IPG;
          cnt_d   = 8'd1;
        end else begin
          state_d = S_DATA;
          tx_d    = {gen_ctrl, gen_data};
          busy_d  = 1'b1;
          term_d  = gen_term;
          byte_d  = byte_q + 15'd4;
          crc_d   = crc_new;
        end
      end
      S_IPG: begin
        if (cnt_q >= ipg_q) begin
          go = enable;
          if (!enable) state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go) begin
      state_d = S_START;
      len_d   = (frame_len < MIN_L) ? MIN_L : frame_len;
      ipg_d   = (ipg_words == 8'd0) ? 8'd1 : ipg_words;
      tx_d    = START_W;
      busy_d  = 1'b1;
    end
  end

  // State and output registers; init_q holds off START for one cycle
  // after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= MIN_L;
      ipg_q    <= 8'd1;
      cnt_q    <= '0;
      byte_q   <= '0;
      crc_q    <= '1;
      tx_q     <= IDLE_W;
      busy_q   <= 1'b0;
      term_q   <= 1'b0;
      init_q   <= 1'b1;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ipg_q    <= ipg_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      crc_q    <= crc_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      term_q   <= term_d;
      init_q   <= init_d;
      frames_q <= frames_d;
    end
  end

  assign xgmii_tx    = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule
